// File: rtl/vote_if.sv
// vote_if: mode/button inputs and tally/pulse/debounced-level outputs of the vote logger.
interface vote_if;
  logic       mode;
  logic       button1, button2, button3, button4;
  logic [7:0] candidate1_vote, candidate2_vote, candidate3_vote, candidate4_vote;
  logic       valid_vote_casted;
  logic       candidate1_button_press, candidate2_button_press;
  logic       candidate3_button_press, candidate4_button_press;
  modport master (
    output mode, button1, button2, button3, button4,
    input  candidate1_vote, candidate2_vote, candidate3_vote, candidate4_vote,
    input  valid_vote_casted,
    input  candidate1_button_press, candidate2_button_press,
    input  candidate3_button_press, candidate4_button_press
  );
  modport slave (
    input  mode, button1, button2, button3, button4,
    output candidate1_vote, candidate2_vote, candidate3_vote, candidate4_vote,
    output valid_vote_casted,
    output candidate1_button_press, candidate2_button_press,
    output candidate3_button_press, candidate4_button_press
  );
endinterface

// File: rtl/vote_logger.sv
// vote_logger: four debounced candidate buttons feeding a single-press vote counter with post-cast lockout.
module vote_logger #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LOCKOUT_CYCLES  = 8
) (
  input logic   clock,
  input logic   reset,
  vote_if.slave bus
);
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, CAST, LOCKOUT} state_t;
  state_t        state, state_nx;
  logic [3:0]    raw, sync1, sync2, deb, deb_q, press;
  logic [7:0]    dcnt [4];
  logic [7:0]    tally [4];
  logic [LW-1:0] lcnt;
  logic [1:0]    sel_nx;
  assign raw    = {bus.button4, bus.button3, bus.button2, bus.button1};
  assign press  = deb & ~deb_q;
  assign sel_nx = press[0] ? 2'd0 : press[1] ? 2'd1 : press[2] ? 2'd2 : 2'd3;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_q <= '0;
      for (int i = 0; i < 4; i++) dcnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_q <= deb;
      for (int i = 0; i < 4; i++)
        if (sync2[i] == deb[i]) dcnt[i] <= '0;
        else if (dcnt[i] == 8'(DEBOUNCE_CYCLES - 1)) begin
          deb[i]  <= sync2[i];
          dcnt[i] <= '0;
        end else dcnt[i] <= dcnt[i] + 8'd1;
    end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      lcnt  <= '0;
      for (int i = 0; i < 4; i++) tally[i] <= '0;
    end else begin
      state <= state_nx;
      // tally is written on entry to CAST so the new value is visible alongside the pulse
      if (state == IDLE && state_nx == CAST && tally[sel_nx] != 8'hFF)
        tally[sel_nx] <= tally[sel_nx] + 8'd1;
      lcnt <= (state == CAST) ? LW'(LOCKOUT_CYCLES) : (lcnt != '0) ? lcnt - LW'(1) : lcnt;
    end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = (!bus.mode && $onehot(press)) ? CAST : IDLE;
      CAST:    state_nx = LOCKOUT;
      LOCKOUT: state_nx = (lcnt == '0 && deb == '0) ? IDLE : LOCKOUT;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    bus.valid_vote_casted       = state == CAST;
    bus.candidate1_vote         = tally[0];
    bus.candidate2_vote         = tally[1];
    bus.candidate3_vote         = tally[2];
    bus.candidate4_vote         = tally[3];
    bus.candidate1_button_press = deb[0];
    bus.candidate2_button_press = deb[1];
    bus.candidate3_button_press = deb[2];
    bus.candidate4_button_press = deb[3];
  end
endmodule

// File: tb/tb_vote_logger.sv
// tb_vote_logger: scoreboard bench; expected tally snapshots are queued per intended vote and popped on each pulse.
module tb_vote_logger;
  logic clock = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;
  logic [31:0] sbq [$];
  logic [31:0] cur_exp = '0;
  logic [7:0]  exp_t [4] = '{default: 8'h00};
  vote_if bus ();
  vote_logger dut (.clock(clock), .reset(rst_n), .bus(bus));
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [31:0] obs();
    return {bus.candidate4_vote, bus.candidate3_vote, bus.candidate2_vote, bus.candidate1_vote};
  endfunction
  function automatic logic [3:0] obs_deb();
    return {bus.candidate4_button_press, bus.candidate3_button_press,
            bus.candidate2_button_press, bus.candidate1_button_press};
  endfunction
  always @(negedge clock) begin
    if (!rst_n) cur_exp = '0;
    else if (bus.valid_vote_casted) begin
      pulses++;
      if (sbq.size() == 0) chk("unexpected_pulse", 32'd1, 32'd0);
      else begin
        cur_exp = sbq.pop_front();
        chk("tally_on_cast", obs(), cur_exp);
      end
    end else chk("tally_hold", obs(), cur_exp);
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  task automatic set_btn(input logic [3:0] v);
    {bus.button4, bus.button3, bus.button2, bus.button1} = v;
  endtask
  task automatic expect_vote(input int c);
    if (exp_t[c] != 8'hFF) exp_t[c] = exp_t[c] + 8'd1;
    sbq.push_back({exp_t[3], exp_t[2], exp_t[1], exp_t[0]});
  endtask
  task automatic clear_model();
    exp_t = '{default: 8'h00};
    sbq.delete();
  endtask
  task automatic vote(input int c);
    set_btn(4'b1 << c);
    expect_vote(c);
    tick(12);
    set_btn(4'b0);
    tick(10);
  endtask
  initial begin
    logic [6:0] lat;
    int p0;
    bus.mode = 1'b0;
    set_btn(4'b0);
    tick(3);
    chk("reset_tally", obs(), 32'd0);
    chk("reset_valid", 32'(bus.valid_vote_casted), 32'd0);
    chk("reset_deb", 32'(obs_deb()), 32'd0);
    rst_n = 1'b1;
    tick(3);
    set_btn(4'b0010);
    expect_vote(1);
    for (int k = 0; k < 7; k++) begin
      @(posedge clock);
      @(negedge clock);
      lat[k] = bus.valid_vote_casted;
    end
    chk("latency_b2", 32'(lat), 32'h40);
    chk("c2_first", 32'(bus.candidate2_vote), 32'd1);
    tick(5);
    set_btn(4'b0);
    tick(10);
    set_btn(4'b0001); tick(1);
    set_btn(4'b0000); tick(1);
    set_btn(4'b0001);
    expect_vote(0);
    tick(15);
    set_btn(4'b0);
    tick(10);
    chk("c1_bounce", 32'(bus.candidate1_vote), 32'd1);
    set_btn(4'b0100);
    expect_vote(2);
    tick(100);
    chk("c3_held", 32'(bus.candidate3_vote), 32'd1);
    set_btn(4'b0);
    tick(10);
    vote(2);
    chk("c3_second", 32'(bus.candidate3_vote), 32'd2);
    set_btn(4'b1001);
    tick(15);
    chk("dual_rejected", obs(), {exp_t[3], exp_t[2], exp_t[1], exp_t[0]});
    set_btn(4'b0);
    tick(12);
    vote(3);
    chk("c4_after_dual", 32'(bus.candidate4_vote), 32'd1);
    bus.mode = 1'b1;
    set_btn(4'b0001);
    tick(10);
    chk("mode1_deb", 32'(bus.candidate1_button_press), 32'd1);
    set_btn(4'b0);
    tick(10);
    bus.mode = 1'b0;
    set_btn(4'b0010);
    expect_vote(1);
    tick(7);
    bus.mode = 1'b1;
    tick(5);
    set_btn(4'b0);
    tick(12);
    bus.mode = 1'b0;
    vote(0);
    chk("c1_after_mode", 32'(bus.candidate1_vote), 32'd2);
    set_btn(4'b0100);
    expect_vote(2);
    tick(10);
    rst_n = 1'b0;
    clear_model();
    #1;
    chk("rst_lockout_tally", obs(), 32'd0);
    chk("rst_lockout_valid", 32'(bus.valid_vote_casted), 32'd0);
    chk("rst_lockout_deb", 32'(obs_deb()), 32'd0);
    set_btn(4'b0);
    tick(3);
    rst_n = 1'b1;
    tick(20);
    set_btn(4'b0001);
    tick(4);
    rst_n = 1'b0;
    set_btn(4'b0);
    tick(2);
    rst_n = 1'b1;
    tick(15);
    chk("rst_debounce_none", obs(), 32'd0);
    rst_n = 1'b0;
    set_btn(4'b1000);
    tick(2);
    rst_n = 1'b1;
    expect_vote(3);
    tick(12);
    set_btn(4'b0);
    tick(12);
    chk("held_through_reset", 32'(bus.candidate4_vote), 32'd1);
    p0 = pulses;
    for (int i = 0; i < 256; i++) vote(1);
    chk("sat_pulses", 32'(pulses - p0), 32'd256);
    chk("sat_c2", 32'(bus.candidate2_vote), 32'hFF);
    chk("queue_empty", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vote_logger.md
VOTE_LOGGER -- requirements
Module: vote_logger

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 4, number of consecutive stable synchronized samples required to accept a button level change (legal range 1..255).
REQ-002 Parameter: LOCKOUT_CYCLES, default 8, minimum cycles after a cast before the next vote is accepted (legal range 1..2^20).
REQ-003 clock  input  1  single clock; all state is updated on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; 0 clears all state immediately, release is taken on a clock edge.
REQ-005 mode  input  1  0 = voting mode, 1 = result mode.
REQ-006 button1..button4  input  1 each  raw, asynchronous, bouncing candidate push buttons, active-high.
REQ-007 candidate1_vote..candidate4_vote  output  8 each  per-candidate vote tallies.
REQ-008 valid_vote_casted  output  1  single-cycle pulse, high in the cycle a vote is counted.
REQ-009 candidate1_button_press..candidate4_button_press  output  1 each  debounced button levels, provided for result-mode selection.

Function
REQ-010 Each button SHALL pass through a two-flop synchronizer before any other logic uses it.
REQ-011 Each synchronized button SHALL have its own debounce counter; the debounced level SHALL take the synchronized value only after that value differs from the current debounced level for DEBOUNCE_CYCLES consecutive cycles; any intermediate bounce SHALL restart the count.
REQ-012 A press event SHALL be a 0->1 transition of a debounced level; a release SHALL generate no event.
REQ-013 Controller states: IDLE, CAST, LOCKOUT.
REQ-014 IDLE: if mode=0 and exactly one press event occurs, go to CAST and register the candidate index; otherwise remain in IDLE.
REQ-015 CAST (one cycle): assert valid_vote_casted, increment the registered candidate tally, load the lockout counter with LOCKOUT_CYCLES, go to LOCKOUT.
REQ-016 LOCKOUT: decrement the lockout counter each cycle; return to IDLE only when the counter is 0 and all four debounced levels are 0; press events in LOCKOUT SHALL be discarded, not queued.
REQ-017 Latency: if the raw button rises cleanly at edge t, valid_vote_casted SHALL be high in cycle t+2+DEBOUNCE_CYCLES+1, and the tally SHALL show the new value in the same cycle.
REQ-018 Simultaneous press events on two or more buttons in the same IDLE cycle SHALL be rejected: no pulse, no tally change, state remains IDLE.
REQ-019 Tallies SHALL saturate at 8'hFF; a cast for a saturated candidate SHALL still pulse valid_vote_casted and enter LOCKOUT, but SHALL leave the tally at 8'hFF.
REQ-020 Press events while mode=1 SHALL be ignored for counting; debounced outputs SHALL still track the buttons.
REQ-021 A mode change to 1 during CAST or LOCKOUT SHALL NOT abort the in-progress cast; the sequence SHALL complete normally.
REQ-022 At most one tally SHALL change per clock, and only in CAST.

Reset
REQ-023 While reset=0: all tallies 8'h00, valid_vote_casted 0, debounced levels 0, synchronizers 0, debounce and lockout counters 0, state IDLE.
REQ-024 Reset asserted mid-debounce, in CAST, or in LOCKOUT SHALL discard the in-progress event with no pulse after release.
REQ-025 A button held through reset release SHALL be counted once it has been debounced, which requires mode=0.

Verification
REQ-026 Clean press of button2 with DEBOUNCE_CYCLES=4 -> one valid_vote_casted pulse 7 cycles after the raw edge; candidate2_vote 0->1; other tallies 0.
REQ-027 button1 bouncing 1-0-1 within 3 cycles, then stable high -> exactly one vote; candidate1_vote=1.
REQ-028 button3 held high for 100 cycles -> exactly one vote; a second vote is taken only after release, debounce, LOCKOUT expiry and a new press.
REQ-029 button1 and button4 pressed on the same edge -> no pulse, both tallies stay 0; releasing both and pressing button4 alone -> candidate4_vote=1.
REQ-030 256 separated button2 votes -> candidate2_vote stays 8'hFF after the 255th vote; 256 pulses observed.
REQ-031 mode=1 with button1 pressed -> no pulse, candidate1_button_press=1; reset driven low in LOCKOUT -> all outputs 0 immediately, with no pulse after reset is released.
